// File: rtl/load_store_unit.sv
// load_store_unit: RV32I LB/LH/LW/LBU/LHU/SB/SH/SW onto a word-only bus; SB/SH are read-modify-write. LSU_MISALIGN_TRAP_EN enables misalign/funct3 traps.
// Accept edge to resp_valid: SW 2, loads 3, SB/SH 4 (trap 2); req_ready is high only in IDLE, so one request is in flight at a time.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] data_bus_addr,
    output logic [1:0]  data_bus_mode,
    inout  wire  [31:0] data_bus_data
);

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;

`ifdef LSU_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR} state_t;
`endif

    state_t      state;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [31:0] wr_word;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // The bus is only ever driven by us while a write is on it.
    assign data_bus_data = (data_bus_mode == MODE_WRITE) ? wr_word : 32'bz;

    // Halves use lane {offset[1],0}, so a misaligned half falls back to its containing half.
    always_comb begin
        sel_byte = data_bus_data[{offset_q, 3'b000} +: 8];
        sel_half = offset_q[1] ? data_bus_data[31:16] : data_bus_data[15:0];
        load_val = data_bus_data;
        merged   = data_bus_data;
        case (funct3_q[1:0])
            2'b00: begin
                load_val = {{24{~funct3_q[2] & sel_byte[7]}}, sel_byte};
                merged[{offset_q, 3'b000} +: 8] = wr_word[7:0];
            end
            2'b01: begin
                load_val = {{16{~funct3_q[2] & sel_half[15]}}, sel_half};
                if (offset_q[1])
                    merged[31:16] = wr_word[15:0];
                else
                    merged[15:0] = wr_word[15:0];
            end
            default: begin
                load_val = data_bus_data;
                merged   = data_bus_data;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic fault;
    logic resp_error_q;

    always_comb begin
        fault = 1'b0;
        if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11)
            fault = 1'b1;
        else if (req_funct3[1:0] == 2'b01 && req_addr[0])
            fault = 1'b1;
        else if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
            fault = 1'b1;
    end

    assign resp_error = resp_error_q;
`else
    assign resp_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'd0;
            data_bus_addr <= 32'd0;
            data_bus_mode <= MODE_IDLE;
            write_q       <= 1'b0;
            funct3_q      <= 3'b000;
            offset_q      <= 2'b00;
            wr_word       <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            resp_error_q  <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            resp_error_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q       <= req_write;
                        funct3_q      <= req_funct3;
                        offset_q      <= req_addr[1:0];
                        wr_word       <= req_wdata;
                        data_bus_addr <= {req_addr[31:2], 2'b00};
                        resp_rdata    <= 32'd0;
                        req_ready     <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (fault) begin
                            state <= S_ERR;
                        end else
`endif
                        if (req_write && req_funct3[1]) begin
                            state         <= S_WR;
                            data_bus_mode <= MODE_WRITE;
                        end else begin
                            state         <= S_RD_ADDR;
                            data_bus_mode <= MODE_READ;
                        end
                    end
                end
                S_RD_ADDR: begin
                    state <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    if (write_q) begin
                        wr_word       <= merged;
                        state         <= S_WR;
                        data_bus_mode <= MODE_WRITE;
                    end else begin
                        resp_rdata    <= load_val;
                        resp_valid    <= 1'b1;
                        req_ready     <= 1'b1;
                        state         <= S_IDLE;
                        data_bus_mode <= MODE_IDLE;
                    end
                end
                S_WR: begin
                    resp_rdata    <= 32'd0;
                    resp_valid    <= 1'b1;
                    req_ready     <= 1'b1;
                    state         <= S_IDLE;
                    data_bus_mode <= MODE_IDLE;
                end
`ifdef LSU_MISALIGN_TRAP_EN
                S_ERR: begin
                    resp_rdata    <= 32'd0;
                    resp_valid    <= 1'b1;
                    resp_error_q  <= 1'b1;
                    req_ready     <= 1'b1;
                    state         <= S_IDLE;
                    data_bus_mode <= MODE_IDLE;
                end
`endif
                default: begin
                    req_ready     <= 1'b1;
                    state         <= S_IDLE;
                    data_bus_mode <= MODE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory on the bus, directed scenarios plus random ops against a reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] data_bus_addr;
    logic [1:0]  data_bus_mode;
    wire  [31:0] data_bus_data;

    int errors = 0;
    int checks = 0;
    int idle_bad = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .data_bus_addr(data_bus_addr), .data_bus_mode(data_bus_mode),
        .data_bus_data(data_bus_data)
    );

    // Word-only memory: registered read, single-cycle write, plus a preload port.
    logic [31:0] mem [0:1023];
    logic [31:0] mem_rd;
    logic        pre_we;
    logic [9:0]  pre_idx;
    logic [31:0] pre_val;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_idx] <= pre_val;
        else if (data_bus_mode == 2'b10)
            mem[data_bus_addr[11:2]] <= data_bus_data;
        if (data_bus_mode == 2'b01)
            mem_rd <= mem[data_bus_addr[11:2]];
    end

    assign data_bus_data = (data_bus_mode == 2'b01) ? mem_rd : 32'bz;

    always @(negedge clk)
        if (reset && req_ready && data_bus_mode != 2'b00)
            idle_bad++;

    // Reference model: memory as plain words, accesses by arithmetic on byte offsets.
    logic [31:0] ref_mem [0:1023];

    logic [31:0] g_rd, g_wdat, g_addr, e_rd;
    logic        g_er, e_er;
    logic [15:0] g_trace;
    int          g_lat, g_waits, e_lat;

    task automatic model_op(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] rd,
                            output logic er, output int lat);
        int idx, off, size;
        logic [31:0] word, mask, val;
        idx  = int'(a[11:2]);
        off  = int'(a % 4);
        word = ref_mem[idx];
        size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        rd = 32'd0;
        er = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (size == 2 && off % 2 != 0) ||
            (size == 4 && off != 0)) begin
            er  = 1'b1;
            lat = 2;
            return;
        end
`endif
        if (size == 2) off = off - off % 2;
        if (size == 4) off = 0;
        mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (!wr) begin
            val = (word >> (8 * off)) & mask;
            if (f3 < 3'd4 && size < 4 && val >= (mask + 1) / 2)
                val = val | ~mask;
            rd  = val;
            lat = 3;
        end else if (size == 4) begin
            ref_mem[idx] = wd;
            lat = 2;
        end else begin
            ref_mem[idx] = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
            lat = 4;
        end
    endtask

    // Drive one request from #1 after a rising edge; returns at the resp_valid cycle.
    task automatic do_req(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold);
        g_waits = 0;
        while (!req_ready && g_waits < 20) begin
            @(posedge clk); #1;
            g_waits++;
        end
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        g_addr  = data_bus_addr;
        g_lat   = 1;
        g_trace = 16'd0;
        g_wdat  = 32'd0;
        while (!resp_valid && g_lat < 20) begin
            g_trace = {g_trace[13:0], data_bus_mode};
            if (data_bus_mode == 2'b10) g_wdat = data_bus_data;
            @(posedge clk); #1;
            g_lat++;
        end
        g_rd = resp_rdata;
        g_er = resp_error;
    endtask

    task automatic op(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input bit hold);
        model_op(wr, f3, a, wd, e_rd, e_er, e_lat);
        do_req(wr, f3, a, wd, hold);
    endtask

    task automatic test_reset;
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; pre_we = 1'b0; pre_idx = 10'd0; pre_val = 32'd0;
        #1;
        for (int i = 0; i < 1024; i++) begin
            pre_we = 1'b1; pre_idx = 10'(i); pre_val = $urandom;
            ref_mem[i] = pre_val;
            @(posedge clk); #1;
        end
        pre_we = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
        checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h want=0", resp_rdata); end
        checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b want=0", resp_error); end
        checks++; if (data_bus_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got=%h want=0", data_bus_addr); end
        checks++; if (data_bus_mode !== 2'b00) begin errors++; $display("FAIL reset_mode got=%b want=00", data_bus_mode); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sw_lw;
        op(1'b1, 3'b010, 32'h2004, 32'hDEADBEEF, 1'b0);
        checks++; if (g_trace !== 16'h0002) begin errors++; $display("FAIL sw_trace got=%h want=0002", g_trace); end
        checks++; if (g_wdat !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_bus_data got=%h want=deadbeef", g_wdat); end
        checks++; if (g_lat !== 2) begin errors++; $display("FAIL sw_latency got=%0d want=2", g_lat); end
        checks++; if (g_rd !== 32'd0) begin errors++; $display("FAIL sw_rdata got=%h want=0", g_rd); end
        op(1'b0, 3'b010, 32'h2004, 32'd0, 1'b0);
        checks++; if (g_lat !== 3) begin errors++; $display("FAIL lw_latency got=%0d want=3", g_lat); end
        checks++; if (g_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got=%h want=deadbeef", g_rd); end
        checks++; if (g_addr !== 32'h2004) begin errors++; $display("FAIL lw_addr got=%h want=2004", g_addr); end
    endtask

    task automatic test_subword_loads;
        logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adrs [4] = '{32'h2009, 32'h200B, 32'h200A, 32'h200A};
        logic [31:0] want [4] = '{32'h0000007F, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
        op(1'b1, 3'b010, 32'h2008, 32'h80FF7F01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            op(1'b0, f3s[i], adrs[i], 32'd0, 1'b0);
            checks++;
            if (g_rd !== want[i] || g_lat !== 3) begin
                errors++;
                $display("FAIL subword_load[%0d] got=%h lat=%0d want=%h lat=3", i, g_rd, g_lat, want[i]);
            end
        end
    endtask

    task automatic test_rmw;
        op(1'b1, 3'b010, 32'h200C, 32'h11223344, 1'b0);
        op(1'b1, 3'b000, 32'h200D, 32'h000000AA, 1'b0);
        checks++; if (g_trace !== 16'h0016) begin errors++; $display("FAIL sb_trace got=%h want=0016", g_trace); end
        checks++; if (g_lat !== 4) begin errors++; $display("FAIL sb_latency got=%0d want=4", g_lat); end
        checks++; if (g_wdat !== 32'h1122AA44) begin errors++; $display("FAIL sb_bus_data got=%h want=1122aa44", g_wdat); end
        op(1'b0, 3'b010, 32'h200C, 32'd0, 1'b0);
        checks++; if (g_rd !== 32'h1122AA44) begin errors++; $display("FAIL sb_readback got=%h want=1122aa44", g_rd); end
        op(1'b1, 3'b001, 32'h200E, 32'h0000BEEF, 1'b0);
        checks++; if (g_lat !== 4) begin errors++; $display("FAIL sh_latency got=%0d want=4", g_lat); end
        op(1'b0, 3'b010, 32'h200C, 32'd0, 1'b0);
        checks++; if (g_rd !== 32'hBEEFAA44) begin errors++; $display("FAIL sh_readback got=%h want=beefaa44", g_rd); end
    endtask

    task automatic test_reset_abort;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h200D; req_wdata = 32'h00000055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++; if (data_bus_mode !== 2'b00) begin errors++; $display("FAIL abort_mode got=%b want=00", data_bus_mode); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b want=1", req_ready); end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (mem[10'h003] !== 32'hBEEFAA44) begin errors++; $display("FAIL abort_mem got=%h want=beefaa44", mem[10'h003]); end
        op(1'b0, 3'b010, 32'h200C, 32'd0, 1'b0);
        checks++; if (g_rd !== 32'hBEEFAA44) begin errors++; $display("FAIL abort_readback got=%h want=beefaa44", g_rd); end
    endtask

    task automatic test_misalign;
        op(1'b1, 3'b010, 32'h2000, 32'h0BADF00D, 1'b0);
        op(1'b0, 3'b010, 32'h2002, 32'd0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (g_trace !== 16'h0000) begin errors++; $display("FAIL trap_trace got=%h want=0000", g_trace); end
        checks++; if (g_lat !== 2) begin errors++; $display("FAIL trap_latency got=%0d want=2", g_lat); end
        checks++; if (g_er !== 1'b1 || g_rd !== 32'd0) begin errors++; $display("FAIL trap_resp got=%b/%h want=1/0", g_er, g_rd); end
`else
        checks++; if (g_rd !== 32'h0BADF00D) begin errors++; $display("FAIL misalign_lw got=%h want=0badf00d", g_rd); end
        checks++; if (g_addr !== 32'h2000) begin errors++; $display("FAIL misalign_addr got=%h want=2000", g_addr); end
        checks++; if (g_er !== 1'b0) begin errors++; $display("FAIL misalign_error got=%b want=0", g_er); end
`endif
    endtask

    task automatic test_back_to_back;
        op(1'b1, 3'b010, 32'h2010, 32'h12345678, 1'b1);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b want=1", req_ready); end
        op(1'b0, 3'b010, 32'h2010, 32'd0, 1'b0);
        checks++; if (g_waits !== 0) begin errors++; $display("FAIL b2b_wait got=%0d want=0", g_waits); end
        checks++; if (g_lat !== 3 || g_rd !== 32'h12345678) begin errors++; $display("FAIL b2b_lw got=%h lat=%0d want=12345678 lat=3", g_rd, g_lat); end
    endtask

    task automatic test_random;
        int bad_words;
        logic [2:0] f3;
        bit wr;
        for (int n = 0; n < 300; n++) begin
            wr = 1'($urandom % 2);
            if ($urandom % 8 == 0) f3 = 3'($urandom_range(3, 7));
            else if (wr)           f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            op(wr, f3, 32'h2000 + 32'($urandom_range(0, 4095)), $urandom, 1'b0);
            checks++;
            if (g_rd !== e_rd || g_er !== e_er || g_lat !== e_lat) begin
                errors++;
                $display("FAIL random[%0d] wr=%b f3=%b addr=%h got=%h/%b/%0d want=%h/%b/%0d",
                         n, wr, f3, req_addr, g_rd, g_er, g_lat, e_rd, e_er, e_lat);
            end
        end
        bad_words = 0;
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== ref_mem[i]) bad_words++;
        checks++; if (bad_words != 0) begin errors++; $display("FAIL memory_image got=%0d bad words want=0", bad_words); end
        checks++; if (idle_bad != 0) begin errors++; $display("FAIL idle_mode got=%0d busy idle cycles want=0", idle_bad); end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_subword_loads();
        test_rmw();
        test_reset_abort();
        test_misalign();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
